// File: rtl/execute_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one shared 33-bit add/sub plus shifts, XLEN iterations per op.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies, divide-by-zero and signed overflow finish without iterating.
module execute_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_v,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            result_v,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q, acc_hi_q, acc_lo_q, spec_val_q;
  logic            neg_q, spec_q;

  // Accept-time decode of signedness, magnitudes and special cases
  logic            is_div_in, a_sgn_in, b_sgn_in, a_neg, b_neg, neg_in;
  logic            div_zero, ovf, spec_in, early_in, accept;
  logic [XLEN-1:0] a_abs, b_abs, spec_val_in, early_val;

  always_comb begin
    is_div_in   = op[2];
    a_sgn_in    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn_in    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg       = a_sgn_in & rs1_data[XLEN-1];
    b_neg       = b_sgn_in & rs2_data[XLEN-1];
    a_abs       = a_neg ? -rs1_data : rs1_data;
    b_abs       = b_neg ? -rs2_data : rs2_data;
    neg_in      = (is_div_in & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div_in & (rs2_data == '0);
    ovf         = is_div_in & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data);
    spec_in     = div_zero | ovf;
    if (div_zero)
      spec_val_in = op[1] ? rs1_data : '1;
    else
      spec_val_in = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
    early_in    = spec_in | (~is_div_in & ((rs1_data == '0) | (rs2_data == '0)));
    early_val   = is_div_in ? spec_val_in : '0;
`else
    early_in    = 1'b0;
    early_val   = '0;
`endif
  end

  // Shared adder: multiply adds the multiplicand into the high half, divide subtracts the divisor
  logic            is_div_q, qbit, last_iter;
  logic [XLEN:0]   div_shift, alu_x, alu_y, alu_s;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  always_comb begin
    is_div_q  = op_q[2];
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    alu_x     = is_div_q ? div_shift : {1'b0, acc_hi_q};
    if (is_div_q)
      alu_y = ~{1'b0, opnd_q};
    else
      alu_y = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
    alu_s     = alu_x + alu_y + (XLEN+1)'(is_div_q);
    qbit      = ~alu_s[XLEN];
    if (is_div_q) begin
      hi_nxt = qbit ? alu_s[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_nxt = {acc_lo_q[XLEN-2:0], qbit};
    end else begin
      hi_nxt = alu_s[XLEN:1];
      lo_nxt = {alu_s[0], acc_lo_q[XLEN-1:1]};
    end
    last_iter = (cnt_q == CNT_W'(XLEN-1));
  end

  // Sign fix on the final iteration's outputs; special-case values win
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_raw, fin;

  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = op_q[1] ? hi_nxt : lo_nxt;
    if (spec_q)
      fin = spec_val_q;
    else if (is_div_q)
      fin = neg_q ? -div_raw : div_raw;
    else if (op_q[1:0] == 2'd0)
      fin = prod_fix[XLEN-1:0];
    else
      fin = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    stall    = 1'b0;
    result_v = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start_v;
        if (start_v && !flush) begin
          accept  = 1'b1;
          state_d = early_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush)
          state_d = IDLE;
        else if (last_iter)
          state_d = DONE;
      end
      DONE: begin
        result_v = ~flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      spec_val_q <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      result     <= '0;
      result_rd  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op;
        rd_q       <= rd;
        opnd_q     <= is_div_in ? b_abs : a_abs;
        acc_lo_q   <= is_div_in ? a_abs : b_abs;
        acc_hi_q   <= '0;
        neg_q      <= neg_in;
        spec_q     <= spec_in;
        spec_val_q <= spec_val_in;
        cnt_q      <= '0;
        if (early_in) begin
          result    <= early_val;
          result_rd <= rd;
        end
      end else if (state_q == BUSY && !flush) begin
        acc_hi_q <= hi_nxt;
        acc_lo_q <= lo_nxt;
        cnt_q    <= cnt_q + 1'b1;
        if (last_iter) begin
          result    <= fin;
          result_rd <= rd_q;
        end
      end
    end
  end

endmodule

// File: doc/execute_muldiv_ctrl.md
Name: execute_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer beside the execute stage; implements RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Accepts one operation from register-fetch, stalls the front of the pipeline while it iterates, then presents one result for the execute→memory register to capture.
- Uses one shared 33-bit add/sub and shift datapath for every op; no combinational multiplier.

Parameters:
- XLEN, 32, operand/result width in bits; the iteration count equals XLEN.
- CNT_W, 5, iteration counter width; must equal clog2(XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_v  in  1  op request from register-fetch; valid only when the decoded op is an M-extension op
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  in  XLEN  operand a (multiplicand/dividend)
- rs2_data  in  XLEN  operand b (multiplier/divisor)
- rd  in  5  destination register
- flush  in  1  kill the in-flight op
- stall  out  1  hold the upstream stages
- result_v  out  1  result valid, single-cycle pulse
- result  out  XLEN  result data
- result_rd  out  5  destination register of the result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. All state updates on posedge clk.
- Reset: state IDLE, counter 0, result_v 0, result 0, result_rd 0. stall is 0 because it is combinational from state.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - When start_v=1 and flush=0: latch op, rd and the operand magnitudes. Signed operands (MULH/MULHSU a and b per RV spec; DIV/REM both) are converted to absolute value.
  - Also latch a result-negate flag and the special-case flags, clear the counter and go to BUSY.
- BUSY:
  - Each cycle performs one iteration. Multiply uses shift-add on a 2*XLEN accumulator, LSB first. Divide uses restoring steps, one quotient bit per cycle, MSB first.
  - Counter increments each cycle. On the iteration with counter==XLEN-1, go to DONE.
- DONE:
  - result_v=1 for exactly one cycle; result and result_rd are held registered.
  - Next state is IDLE; result_v clears on the following edge.
- Latency: the accepting edge is E0. Iteration edges are E1..E32. result_v is high in the cycle after E32, i.e. a 33-cycle occupancy.
- stall = (IDLE & start_v) | BUSY. stall is low in DONE, so the pipeline advances and captures result.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Sign fix after iteration: a negated product uses two's complement on the full 2*XLEN. A negated quotient applies when the operand signs differ. The remainder takes the dividend's sign.
- Divide-by-zero (b=0): quotient all ones; remainder = original rs1_data. Applies to both signed and unsigned forms.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- Special-case flags are decided at accept and override the iterated result in DONE.
- flush:
  - In BUSY or DONE, flush=1 sends the block to IDLE next edge with result_v forced 0 and no result produced.
  - In IDLE, flush=1 blocks acceptance of start_v that cycle.
- start_v while BUSY/DONE is ignored; upstream is stalled, so the request is re-presented.
- Reset mid-operation: immediate return to IDLE; the partial result is discarded.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- Defined: at accept, any of these go IDLE→DONE directly with no BUSY cycles, so result_v is high in the cycle after E0:
  - a multiply op with either operand zero: result 0;
  - a divide op with b=0;
  - the signed-overflow case.
  stall is then high only in the accept cycle.
- Undefined: every op takes the full XLEN iterations; special-case values are applied in DONE after 33 cycles.

Test Plan:
- MUL a=7, b=6, rd=5 → stall high for 33 cycles, then result_v pulse with result=42, result_rd=5.
- MULH a=0xFFFFFFFF(-1), b=0x00000002 → result=0xFFFFFFFF. Then MULHU with the same operands → result=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 → result=0xFFFFFFFD(-3). REM with the same operands → result=0xFFFFFFFF(-1).
- DIVU a=100, b=0 → result=0xFFFFFFFF. REMU a=100, b=0 → result=100. With MULDIV_EARLY_OUT_EN, result_v is one cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF → result=0x80000000. REM with the same operands → result=0.
- Start DIVU 1000/3, assert flush at iteration 10 → IDLE next edge, no result_v. A new MUL 3*3 is then accepted immediately → result=9. Separately, assert rst at iteration 5 → all outputs 0 on the next cycle.
